// File: rtl/uart_reg_controller_if.sv
// CPU-side register bus of the UART register controller: chip select, direction,
// register offset and the write/read data paths.
interface uart_reg_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cs;
  logic                  we;
  logic [1:0]            addr_offset;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output cs, we, addr_offset, data_in, input data_out);
  modport slave  (input cs, we, addr_offset, data_in, output data_out);
endinterface

// File: rtl/uart_reg_controller.sv
// Register front end for the UART engines: CONFIG/STATUS/DATA/COMMAND decode,
// TX/RX byte FIFOs, TX start/busy sequencer and sticky error flags.
module uart_reg_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int TX_FIFO_DEPTH = 4,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_reg_controller_if.slave  bus,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_frame_err,
  output logic                  irq
);

  typedef enum logic [1:0] {
    REG_CONFIG  = 2'b00,
    REG_STATUS  = 2'b01,
    REG_DATA    = 2'b10,
    REG_COMMAND = 2'b11
  } uart_reg_offset_e;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SETTLE, TX_WAIT} tx_state_e;

  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam int TX_PW = TX_AW + 1;
  localparam int RX_PW = RX_AW + 1;

  logic [DATA_WIDTH-1:0] r_tx_mem [TX_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [RX_FIFO_DEPTH];
  logic [TX_PW-1:0]      r_tx_wr, r_tx_rd;
  logic [RX_PW-1:0]      r_rx_wr, r_rx_rd;
  logic                  r_tx_en, r_rx_en, r_irq_en;
  logic                  r_rx_ovr, r_ferr, r_tx_ovf;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] r_data_out;
  tx_state_e             r_state;

  uart_reg_offset_e      w_offset;
  logic                  w_wr, w_rd, w_data_wr, w_data_rd, w_cfg_wr, w_cmd_wr;
  logic                  w_tx_flush, w_rx_flush, w_clr_sticky;
  logic                  w_tx_empty, w_tx_full, w_tx_pop, w_tx_push, w_tx_ovf;
  logic                  w_rx_empty, w_rx_full, w_rx_take, w_rx_pop, w_rx_push, w_rx_ovr;
  logic                  w_ferr;
  logic [7:0]            w_status;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_offset     = uart_reg_offset_e'(bus.addr_offset);
  assign w_wr         = bus.cs & bus.we;
  assign w_rd         = bus.cs & ~bus.we;
  assign w_cfg_wr     = w_wr & (w_offset == REG_CONFIG);
  assign w_data_wr    = w_wr & (w_offset == REG_DATA);
  assign w_data_rd    = w_rd & (w_offset == REG_DATA);
  assign w_cmd_wr     = w_wr & (w_offset == REG_COMMAND);
  assign w_tx_flush   = w_cmd_wr & bus.data_in[0];
  assign w_rx_flush   = w_cmd_wr & bus.data_in[1];
  assign w_clr_sticky = w_cmd_wr & bus.data_in[2];

  // Full when the wrap bits differ but the index bits match.
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[TX_AW] != r_tx_rd[TX_AW]) &&
                      (r_tx_wr[TX_AW-1:0] == r_tx_rd[TX_AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[RX_AW] != r_rx_rd[RX_AW]) &&
                      (r_rx_wr[RX_AW-1:0] == r_rx_rd[RX_AW-1:0]);

  // A same-cycle sequencer pop frees a slot, so a write to a full FIFO still lands.
  assign w_tx_pop  = (r_state == TX_IDLE) & r_tx_en & ~w_tx_empty & ~w_tx_flush;
  assign w_tx_push = w_data_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf  = w_data_wr & w_tx_full & ~w_tx_pop;

  assign w_rx_take = rx_valid & r_rx_en & ~rx_frame_err;
  assign w_rx_pop  = w_data_rd & ~w_rx_empty;
  assign w_rx_push = w_rx_take & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr  = w_rx_take & w_rx_full & ~w_rx_pop;
  assign w_ferr    = rx_valid & rx_frame_err;

  assign w_status = {1'b0, (r_state != TX_IDLE), r_tx_ovf, r_ferr, r_rx_ovr,
                     ~w_rx_empty, w_tx_full, w_tx_empty};

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    case (w_offset)
      REG_CONFIG:  w_rd_data = DATA_WIDTH'({r_irq_en, r_rx_en, r_tx_en});
      REG_STATUS:  w_rd_data = DATA_WIDTH'(w_status);
      REG_DATA:    w_rd_data = w_rx_empty ? '0 : r_rx_mem[r_rx_rd[RX_AW-1:0]];
      REG_COMMAND: w_rd_data = '0;
      default:     w_rd_data = '0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_tx_en    <= 1'b1;
      r_rx_en    <= 1'b1;
      r_irq_en   <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_ferr     <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_data_out <= '0;
    end else begin
      if (w_tx_flush) begin
        r_tx_wr <= '0;
        r_tx_rd <= '0;
      end else begin
        if (w_tx_push) r_tx_wr <= r_tx_wr + TX_PW'(1);
        if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_PW'(1);
      end
      if (w_rx_flush) begin
        r_rx_wr <= '0;
        r_rx_rd <= '0;
      end else begin
        if (w_rx_push) r_rx_wr <= r_rx_wr + RX_PW'(1);
        if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_PW'(1);
      end
      if (w_cfg_wr) {r_irq_en, r_rx_en, r_tx_en} <= bus.data_in[2:0];
      if (w_rd)     r_data_out <= w_rd_data;
      // A flag event in the same cycle as a clear leaves the flag set.
      r_rx_ovr <= w_rx_ovr | (r_rx_ovr & ~w_clr_sticky);
      r_ferr   <= w_ferr   | (r_ferr   & ~w_clr_sticky);
      r_tx_ovf <= w_tx_ovf | (r_tx_ovf & ~w_clr_sticky);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= bus.data_in;
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= TX_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_data  <= r_tx_mem[r_tx_rd[TX_AW-1:0]];
          r_tx_start <= 1'b1;
          r_state    <= TX_START;
        end
        TX_START:  r_state <= TX_SETTLE;
        TX_SETTLE: r_state <= TX_WAIT;
        TX_WAIT:   if (!tx_busy) r_state <= TX_IDLE;
        default:   r_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign irq          = r_irq_en & ~w_rx_empty;

endmodule

// File: tb/tb_uart_reg_controller.sv
// Scoreboard bench for uart_reg_controller: expected read data and TX bytes are
// queued at stimulus time and compared by monitors when the DUT presents them.
module tb_uart_reg_controller;

  localparam logic [1:0] A_CFG = 2'b00, A_STS = 2'b01, A_DAT = 2'b10, A_CMD = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start, tx_busy, rx_valid, rx_frame_err, irq;
  logic [7:0] tx_data, rx_data;

  uart_reg_controller_if #(.DATA_WIDTH(8)) bus ();

  uart_reg_controller #(.DATA_WIDTH(8), .TX_FIFO_DEPTH(4), .RX_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         tx_count = 0;
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       rd_seen = 1'b0;
  logic [7:0] rd_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Transmitter model: busy for busy_len cycles after each start pulse.
  always @(posedge clk) begin
    if (reset)              busy_cnt <= 0;
    else if (tx_start)      busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) rd_seen <= bus.cs & ~bus.we & ~reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got %02h expected no read", bus.data_out);
      end else begin
        check(rd_name_q.pop_front(), bus.data_out, rd_q.pop_front());
      end
    end
    if (tx_start) begin
      tx_count++;
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tx_start: got %02h expected no start", tx_data);
      end else begin
        check("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr_offset = a; bus.data_in = d;
    tick(1);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    rd_q.push_back(exp); rd_name_q.push_back(name);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr_offset = a;
    tick(1);
    bus.cs = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d, input logic fe);
    rx_valid = 1'b1; rx_data = d; rx_frame_err = fe;
    tick(1);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr_offset = 2'b00; bus.data_in = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_tx_start", {7'b0, tx_start}, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    tick(1);

    // Reset register values
    bus_read(A_STS, 8'h01, "rst_status");
    bus_read(A_CFG, 8'h03, "rst_config");
    bus_read(A_DAT, 8'h00, "rst_data_empty");
    bus_read(A_CMD, 8'h00, "command_read");

    // Two bytes through a slow transmitter
    busy_len = 10;
    tx_q.push_back(8'h41); tx_q.push_back(8'h42);
    bus_write(A_DAT, 8'h41);
    bus_write(A_DAT, 8'h42);
    tick(60);
    check("tx2_count", 8'(tx_count), 8'd2);
    bus_read(A_STS, 8'h01, "tx2_status_end");

    // Overflow with transmitter disabled, then drain exactly four bytes
    bus_write(A_CFG, 8'h02);
    for (int i = 1; i <= 5; i++) bus_write(A_DAT, 8'(i));
    bus_read(A_STS, 8'h22, "tx_full_overflow");
    busy_len = 0;
    tx_count = 0;
    for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
    bus_write(A_CFG, 8'h03);
    tick(40);
    check("tx4_count", 8'(tx_count), 8'd4);
    bus_write(A_CMD, 8'h04);
    bus_read(A_STS, 8'h01, "tx_ovf_cleared");

    // RX overrun
    for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i), 1'b0);
    bus_read(A_STS, 8'h0D, "rx_full_overrun");
    for (int i = 0; i < 4; i++) bus_read(A_DAT, 8'h10 + 8'(i), "rx_pop");
    bus_read(A_DAT, 8'h00, "rx_pop_empty");
    bus_read(A_STS, 8'h09, "rx_overrun_sticky");
    bus_write(A_CMD, 8'h04);
    bus_read(A_STS, 8'h01, "rx_overrun_cleared");

    // Framing error discards the byte
    rx_push(8'hAA, 1'b1);
    bus_read(A_STS, 8'h11, "frame_err_flag");
    bus_read(A_DAT, 8'h00, "frame_err_not_stored");
    bus_write(A_CMD, 8'h04);
    // Clear and a new framing error in the same cycle: the flag survives
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr_offset = A_CMD; bus.data_in = 8'h04;
    rx_valid = 1'b1; rx_data = 8'hAB; rx_frame_err = 1'b1;
    tick(1);
    bus.cs = 1'b0; bus.we = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0;
    bus_read(A_STS, 8'h11, "clear_vs_set");
    bus_write(A_CMD, 8'h04);
    bus_read(A_STS, 8'h01, "frame_err_cleared");

    // Interrupt follows RX-not-empty when enabled
    bus_write(A_CFG, 8'h07);
    rx_push(8'h77, 1'b0);
    check("irq_set", {7'b0, irq}, 8'h01);
    bus_read(A_STS, 8'h05, "irq_status");
    check("irq_held", {7'b0, irq}, 8'h01);
    bus_read(A_DAT, 8'h77, "irq_byte");
    check("irq_cleared", {7'b0, irq}, 8'h00);

    // Receiver disabled ignores bytes; flush beats a same-cycle push
    bus_write(A_CFG, 8'h05);
    rx_push(8'h99, 1'b0);
    bus_read(A_DAT, 8'h00, "rx_disabled_ignored");
    bus_write(A_CFG, 8'h03);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr_offset = A_CMD; bus.data_in = 8'h02;
    rx_valid = 1'b1; rx_data = 8'h88;
    tick(1);
    bus.cs = 1'b0; bus.we = 1'b0; rx_valid = 1'b0;
    bus_read(A_DAT, 8'h00, "rx_flush_wins");

    // Full RX FIFO with pop and push in the same cycle
    for (int i = 0; i < 4; i++) rx_push(8'h51 + 8'(i), 1'b0);
    rd_q.push_back(8'h51); rd_name_q.push_back("full_pop_push_head");
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr_offset = A_DAT;
    rx_valid = 1'b1; rx_data = 8'h55;
    tick(1);
    bus.cs = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) bus_read(A_DAT, 8'h52 + 8'(i), "full_pop_push_drain");
    bus_read(A_STS, 8'h01, "full_pop_push_no_ovr");

    // Reset while the sequencer waits on a busy transmitter
    busy_len = 20;
    tx_count = 0;
    tx_q.push_back(8'h66);
    bus_write(A_DAT, 8'h66);
    bus_write(A_DAT, 8'h67);
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("midreset_tx_start", {7'b0, tx_start}, 8'h00);
    bus_read(A_STS, 8'h01, "midreset_status");
    bus_read(A_CFG, 8'h03, "midreset_config");
    tick(30);
    check("midreset_tx_count", 8'(tx_count), 8'd1);
    check("rd_queue_drained", 8'(rd_q.size()), 8'd0);
    check("tx_queue_drained", 8'(tx_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
